// File: rtl/rv_bypass_ctrl_pkg.sv
// Shared types for the ALU1 operand-bypass scheduler.
// Slot layout, bypass-select bundle and select priority helper.
package rv_bypass_ctrl_pkg;

  localparam int unsigned NUM_STAGES = 5;

  typedef struct packed {
    logic alu2;
    logic memory;
    logic write;
    logic wr_back;
  } ctrl_rs_bp_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } bp_slot_t;

  // hit[0] is the alu1 slot (youngest); youngest hit wins
  function automatic ctrl_rs_bp_t bp_sel(input logic [3:0] hit);
    ctrl_rs_bp_t s;
    s = '0;
    unique case (1'b1)
      hit[0]:  s.alu2    = 1'b1;
      hit[1]:  s.memory  = 1'b1;
      hit[2]:  s.write   = 1'b1;
      hit[3]:  s.wr_back = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rv_bypass_ctrl_slot_match.sv
// Source-vs-slot rd comparator for the bypass network.
// Hits only on a used, non-x0 source against a writing slot.
module rv_bypass_slot_match
  import rv_bypass_ctrl_pkg::*;
(
  input  bp_slot_t   slot_i,
  input  logic [4:0] rs_i,
  input  logic       used_i,
  output logic       hit_o
);

  logic slot_wr;

  assign slot_wr = slot_i.valid & (slot_i.rd != 5'd0);
  assign hit_o   = used_i & (rs_i != 5'd0) & slot_wr &
                   (slot_i.rd == rs_i);

endmodule

// File: rtl/rv_bypass_ctrl.sv
// ALU1 bypass-select scheduler with load-use stall detection.
// Tracks rd of in-flight ops alu1..wr_back; selects are registered.
module rv_bypass_ctrl
  import rv_bypass_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic        i_dec_rs1_used,
  input  logic        i_dec_rs2_used,
  input  logic [4:0]  i_dec_rd,
  input  logic        i_dec_reg_write,
  input  logic        i_dec_load,
  output ctrl_rs_bp_t o_rs1_bp,
  output ctrl_rs_bp_t o_rs2_bp,
  output logic        o_stall,
  output logic [31:0] o_stall_cnt
);

  bp_slot_t    slot_q [NUM_STAGES];
  bp_slot_t    slot_d [NUM_STAGES];
  ctrl_rs_bp_t rs1_q, rs1_d;
  ctrl_rs_bp_t rs2_q, rs2_d;
  logic [31:0] cnt_q, cnt_d;

  logic [3:0]  hit1, hit2;
  logic        ld1, ld2;
  logic        kill;
  bp_slot_t    dec_slot;

  for (genvar i = 0; i < 4; i++) begin : g_match
    rv_bypass_slot_match u_m1 (
      .slot_i (slot_q[i]),
      .rs_i   (i_dec_rs1),
      .used_i (i_dec_rs1_used),
      .hit_o  (hit1[i])
    );
    rv_bypass_slot_match u_m2 (
      .slot_i (slot_q[i]),
      .rs_i   (i_dec_rs2),
      .used_i (i_dec_rs2_used),
      .hit_o  (hit2[i])
    );
  end

  rv_bypass_slot_match u_ld1 (
    .slot_i (slot_q[0]),
    .rs_i   (i_dec_rs1),
    .used_i (i_dec_rs1_used),
    .hit_o  (ld1)
  );
  rv_bypass_slot_match u_ld2 (
    .slot_i (slot_q[0]),
    .rs_i   (i_dec_rs2),
    .used_i (i_dec_rs2_used),
    .hit_o  (ld2)
  );

  assign o_stall = i_dec_valid & ~i_flush &
                   slot_q[0].load & (ld1 | ld2);

  assign dec_slot.valid = i_dec_valid & i_dec_reg_write;
  assign dec_slot.rd    = i_dec_rd;
  assign dec_slot.load  = i_dec_load;

  assign kill = o_stall | i_flush | ~i_dec_valid;

  always_comb begin
    slot_d = slot_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    cnt_d  = cnt_q;
    if (!i_hold) begin
      for (int i = NUM_STAGES - 1; i > 0; i--)
        slot_d[i] = slot_q[i-1];
      slot_d[0] = (o_stall | i_flush) ? '0 : dec_slot;
      rs1_d = kill ? '0 : bp_sel(hit1);
      rs2_d = kill ? '0 : bp_sel(hit2);
      if (o_stall && cnt_q != 32'hFFFF_FFFF)
        cnt_d = cnt_q + 32'd1;
    end else if (i_flush) begin
      slot_d[0] = '0;
      rs1_d     = '0;
      rs2_d     = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_STAGES; i++)
        slot_q[i] <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++)
        slot_q[i] <= slot_d[i];
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_rs1_bp    = rs1_q;
  assign o_rs2_bp    = rs2_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_rv_bypass_ctrl.sv
// Directed bench for rv_bypass_ctrl.
// Hand-computed select/stall expectations per scenario.
module tb_rv_bypass_ctrl;
  import rv_bypass_ctrl_pkg::*;

  localparam logic [31:0] ALU2 = 32'h8;
  localparam logic [31:0] MEM  = 32'h4;
  localparam logic [31:0] WR   = 32'h2;
  localparam logic [31:0] WB   = 32'h1;
  localparam logic [31:0] NONE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        flush;
  logic        dv;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, rw, ld;
  ctrl_rs_bp_t bp1, bp2;
  logic        stall;
  logic [31:0] scnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv_bypass_ctrl dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_hold          (hold),
    .i_flush         (flush),
    .i_dec_valid     (dv),
    .i_dec_rs1       (rs1),
    .i_dec_rs2       (rs2),
    .i_dec_rs1_used  (u1),
    .i_dec_rs2_used  (u2),
    .i_dec_rd        (rd),
    .i_dec_reg_write (rw),
    .i_dec_load      (ld),
    .o_rs1_bp        (bp1),
    .o_rs2_bp        (bp2),
    .o_stall         (stall),
    .o_stall_cnt     (scnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [4:0] s1, input logic e1,
                     input logic [4:0] s2, input logic e2,
                     input logic [4:0] d, input logic w,
                     input logic l);
    dv  = 1'b1;
    rs1 = s1; u1 = e1;
    rs2 = s2; u2 = e2;
    rd  = d;  rw = w; ld = l;
    #1;
  endtask

  task automatic idle(input int n);
    dv = 1'b0; u1 = 1'b0; u2 = 1'b0;
    rw = 1'b0; ld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [31:0] dist_exp [5];

  initial begin
    dist_exp[0] = ALU2; dist_exp[1] = MEM;
    dist_exp[2] = WR;   dist_exp[3] = WB;
    dist_exp[4] = NONE;
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    dv = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    u1 = 1'b0; u2 = 1'b0; rw = 1'b0; ld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_bp1", bp1, NONE);
    chk("rst_bp2", bp2, NONE);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", scnt, 0);

    // add x5 ; sub x6,x5,x5
    dec(0, 0, 0, 0, 5, 1, 0);
    tick();
    dec(5, 1, 5, 1, 6, 1, 0);
    chk("b2b_stall", stall, 0);
    tick();
    chk("b2b_bp1", bp1, ALU2);
    chk("b2b_bp2", bp2, ALU2);
    idle(5);

    // producer x7 at distance 1..5
    for (int d = 1; d <= 5; d++) begin
      dec(0, 0, 0, 0, 7, 1, 0);
      tick();
      for (int k = 0; k < d - 1; k++) begin
        dec(0, 0, 0, 0, 1, 1, 0);
        tick();
      end
      dec(7, 1, 7, 0, 2, 1, 0);
      chk($sformatf("dist%0d_stall", d), stall, 0);
      tick();
      chk($sformatf("dist%0d_bp1", d), bp1, dist_exp[d-1]);
      chk($sformatf("dist%0d_bp2", d), bp2, NONE);
      idle(5);
    end

    // load to x0 then reader of x0
    dec(0, 0, 0, 0, 0, 1, 1);
    tick();
    dec(0, 1, 0, 1, 4, 1, 0);
    chk("x0_stall", stall, 0);
    tick();
    chk("x0_bp1", bp1, NONE);
    chk("x0_bp2", bp2, NONE);
    idle(5);

    // lw x8 ; add x9,x8,x0
    dec(0, 0, 0, 0, 8, 1, 1);
    tick();
    dec(8, 1, 0, 1, 9, 1, 0);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_stall2", stall, 0);
    chk("lu_cnt", scnt, 1);
    chk("lu_bubble_bp1", bp1, NONE);
    tick();
    chk("lu_bp1", bp1, MEM);
    chk("lu_bp2", bp2, NONE);
    chk("lu_cnt2", scnt, 1);
    idle(5);

    // load at distance 2: no stall
    dec(0, 0, 0, 0, 8, 1, 1);
    tick();
    dec(0, 0, 0, 0, 1, 1, 0);
    tick();
    dec(8, 1, 0, 0, 9, 1, 0);
    chk("ld2_stall", stall, 0);
    tick();
    chk("ld2_bp1", bp1, MEM);
    idle(5);

    // hold during chain
    dec(0, 0, 0, 0, 10, 1, 0);
    tick();
    dec(10, 1, 0, 0, 11, 1, 0);
    tick();
    chk("hold_pre", bp1, ALU2);
    hold = 1'b1;
    dec(11, 1, 10, 1, 12, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_bp1", i), bp1, ALU2);
      chk($sformatf("hold%0d_bp2", i), bp2, NONE);
    end
    hold = 1'b0;
    #1;
    tick();
    chk("rel_bp1", bp1, ALU2);
    chk("rel_bp2", bp2, MEM);
    dec(10, 1, 0, 0, 13, 1, 0);
    tick();
    chk("rel2_bp1", bp1, WR);
    idle(5);

    // flush in load-use stall cycle
    dec(0, 0, 0, 0, 3, 1, 0);
    tick();
    dec(0, 0, 0, 0, 8, 1, 1);
    tick();
    dec(8, 1, 0, 0, 9, 1, 0);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("fl_bp1", bp1, NONE);
    chk("fl_bp2", bp2, NONE);
    chk("fl_cnt", scnt, 1);
    dec(8, 1, 3, 1, 9, 1, 0);
    chk("fl_nostall", stall, 0);
    tick();
    chk("fl_old_bp1", bp1, MEM);
    chk("fl_old_bp2", bp2, WR);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_cnt", scnt, 0);
    chk("rst2_bp1", bp1, NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
